// File: rtl/cdp_pkg.sv
// cdp_pkg: shared word type codes, CRC-32 constants, thresholds, FSM state type and per-byte CRC step
package cdp_pkg;
  localparam logic [2:0] HDR = 3'b101;
  localparam logic [2:0] TAIL = 3'b110;
  localparam logic [2:0] MID = 3'b100;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [11:0] MIN_PKT_BYTES = 12'd64;
  localparam logic [7:0] RDY_THRESH = 8'd160;
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ CRC_POLY : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/crc32_d128.sv
// crc32_d128: combinational CRC-32 update; crc_in/data[127:0] (byte 0 = [127:120]) /nbytes 0..16 in, crc_out out
module crc32_d128
  import cdp_pkg::*;
(
  input  logic [31:0]  crc_in,
  input  logic [127:0] data,
  input  logic [4:0]   nbytes,
  output logic [31:0]  crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 16; i++)
      if (5'(i) < nbytes) crc_out = crc32_byte(crc_out, data[127-8*i -: 8]);
  end
endmodule

// File: rtl/crc_check.sv
// crc_check: CRC-32 frame checker; clk/reset(async low), rx_wrreq/rx_data/crc_usedw in, rx_ready, crc_check_wrreq/data, crc_result_wrreq/crc_result out; pkt_good_cnt/pkt_bad_cnt with CRC_CHECK_STATS_EN
module crc_check
  import cdp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_wrreq,
  input  logic [138:0] rx_data,
  output logic         rx_ready,
  output logic         crc_check_wrreq,
  output logic [138:0] crc_check_data,
  input  logic [7:0]   crc_usedw,
  output logic         crc_result_wrreq,
  output logic         crc_result
`ifdef CRC_CHECK_STATS_EN
  ,
  output logic [31:0]  pkt_good_cnt,
  output logic [31:0]  pkt_bad_cnt
`endif
);
  state_t state_q, state_d;
  logic rdy_q, wr_q, wr_d, fwr_q, fwr_d, res_q, res_d, pend_q, pend_d, bad_q, bad_d;
  logic [138:0] data_q, data_d;
  logic [31:0] crc_q, crc_d, crc_nx;
  logic [11:0] len_q, len_d, len_nx;
  logic [12:0] len_sum;
  logic [2:0] typ;
  logic [4:0] nb;
  logic in_pkt;
  assign typ = rx_data[138:136];
  assign in_pkt = state_q == PKT;
  assign nb = typ == TAIL ? {1'b0, rx_data[135:132]} + 5'd1 : 5'd16;
  assign len_sum = (in_pkt ? {1'b0, len_q} : 13'd0) + {8'd0, nb};
  assign len_nx = len_sum[12] ? 12'hFFF : len_sum[11:0];
  crc32_d128 u_crc (
    .crc_in(in_pkt ? crc_q : CRC_INIT),
    .data(rx_data[127:0]),
    .nbytes(nb),
    .crc_out(crc_nx)
  );
  always_comb begin
    state_d = state_q;
    wr_d = 1'b0;
    data_d = data_q;
    crc_d = crc_q;
    len_d = len_q;
    pend_d = 1'b0;
    bad_d = 1'b0;
    if (rx_wrreq && in_pkt && typ == HDR) begin
      state_d = DROP;
      wr_d = 1'b1;
      data_d = {TAIL, 4'hF, rx_data[131:0]};
      pend_d = 1'b1;
      bad_d = 1'b1;
    end else if (rx_wrreq && typ == HDR) begin
      state_d = PKT;
      wr_d = 1'b1;
      data_d = rx_data;
      crc_d = crc_nx;
      len_d = len_nx;
    end else if (rx_wrreq && in_pkt && (typ == MID || typ == TAIL)) begin
      state_d = typ == TAIL ? IDLE : PKT;
      wr_d = 1'b1;
      data_d = rx_data;
      crc_d = crc_nx;
      len_d = len_nx;
      pend_d = typ == TAIL;
    end
    fwr_d = pend_q;
    res_d = pend_q ? !bad_q && crc_q == CRC_RESIDUE && len_q >= MIN_PKT_BYTES : res_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      wr_q <= 1'b0;
      data_q <= '0;
      crc_q <= CRC_INIT;
      len_q <= '0;
      pend_q <= 1'b0;
      bad_q <= 1'b0;
      fwr_q <= 1'b0;
      res_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q <= crc_usedw < RDY_THRESH;
      wr_q <= wr_d;
      data_q <= data_d;
      crc_q <= crc_d;
      len_q <= len_d;
      pend_q <= pend_d;
      bad_q <= bad_d;
      fwr_q <= fwr_d;
      res_q <= res_d;
    end
  assign rx_ready = rdy_q;
  assign crc_check_wrreq = wr_q;
  assign crc_check_data = data_q;
  assign crc_result_wrreq = fwr_q;
  assign crc_result = res_q;
`ifdef CRC_CHECK_STATS_EN
  logic [31:0] good_cnt_q, bad_cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      good_cnt_q <= '0;
      bad_cnt_q <= '0;
    end else if (fwr_q) begin
      good_cnt_q <= good_cnt_q + {31'd0, res_q};
      bad_cnt_q <= bad_cnt_q + {31'd0, !res_q};
    end
  assign pkt_good_cnt = good_cnt_q;
  assign pkt_bad_cnt = bad_cnt_q;
`endif
endmodule

// File: tb/tb_crc_check.sv
// tb_crc_check: table-driven and randomized frame bench for crc_check with a byte-level frame model
`timescale 1ns/1ps
module tb_crc_check;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_wrreq = 1'b0;
  logic [138:0] rx_data = '0;
  logic [7:0] crc_usedw = 8'd0;
  logic rx_ready, crc_check_wrreq, crc_result_wrreq, crc_result;
  logic [138:0] crc_check_data;
`ifdef CRC_CHECK_STATS_EN
  logic [31:0] pkt_good_cnt, pkt_bad_cnt;
`endif
  int errors = 0, checks = 0;
  int n_wr = 0, n_flag = 0, n_good = 0, n_bad = 0;
  logic [138:0] exp_w[$];
  logic exp_f[$];
  logic rnd_usedw = 1'b0;
  logic [7:0] usedw_s = 8'd0;
  logic mon_en = 1'b0;
  logic prev_tail = 1'b0;
  typedef struct {
    int n;
    int corrupt;
    int trunc;
    logic flag;
    int nwr;
  } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  crc_check dut (
    .clk(clk),
    .reset(reset),
    .rx_wrreq(rx_wrreq),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .crc_check_wrreq(crc_check_wrreq),
    .crc_check_data(crc_check_data),
    .crc_usedw(crc_usedw),
    .crc_result_wrreq(crc_result_wrreq),
    .crc_result(crc_result)
`ifdef CRC_CHECK_STATS_EN
    ,
    .pkt_good_cnt(pkt_good_cnt),
    .pkt_bad_cnt(pkt_bad_cnt)
`endif
  );
  task automatic chk(input string name, input logic [138:0] got, input logic [138:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [138:0] rnd139();
    return {11'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'd0, b[i]};
      repeat (8) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction
  always @(posedge clk) begin
    usedw_s <= crc_usedw;
    mon_en <= reset;
  end
  always @(negedge clk) begin
    logic e;
    if (!reset) prev_tail = 1'b0;
    else if (mon_en) begin
      chk("rx_ready", rx_ready, usedw_s < 8'd160);
      if (crc_result_wrreq || prev_tail) chk("flag_timing", crc_result_wrreq, prev_tail);
      if (crc_result_wrreq) begin
        n_flag++;
        if (exp_f.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL flag_extra: got unexpected flag result=%0b, expected none", crc_result);
        end else begin
          e = exp_f.pop_front();
          chk("crc_result", crc_result, e);
          if (e) n_good++;
          else n_bad++;
        end
      end
      if (crc_check_wrreq) begin
        n_wr++;
        if (exp_w.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_extra: got unexpected write %h, expected none", crc_check_data);
        end else chk("write_data", crc_check_data, exp_w.pop_front());
      end
      prev_tail = crc_check_wrreq && crc_check_data[138:136] == 3'b110;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_usedw) crc_usedw = 8'($urandom_range(150, 170));
  endtask
  task automatic put(input logic [138:0] w);
    rx_wrreq = 1'b1;
    rx_data = w;
    tick();
    rx_wrreq = 1'b0;
    rx_data = rnd139();
  endtask
  task automatic send_pkt(input int n, input int corrupt, input int trunc, input int gap, input logic expf);
    logic [7:0] b[$];
    logic [31:0] c;
    logic [138:0] w;
    int nw;
    b = {};
    for (int i = 0; i < n - 4; i++) b.push_back(8'($urandom));
    c = crc_ref(b);
    for (int i = 0; i < 4; i++) b.push_back(c[8*i +: 8]);
    if (corrupt >= 0) b[corrupt] = b[corrupt] ^ 8'hFF;
    nw = (n + 15) / 16;
    for (int k = 0; k < nw; k++) begin
      w = rnd139();
      for (int j = 0; j < 16; j++) if (16 * k + j < n) w[127-8*j -: 8] = b[16*k+j];
      w[138:136] = k == 0 ? 3'b101 : k == nw - 1 ? 3'b110 : 3'b100;
      if (k == nw - 1) w[135:132] = 4'(n - 16 * k - 1);
      if (k == trunc) begin
        w[138:136] = 3'b101;
        exp_w.push_back({3'b110, 4'hF, w[131:0]});
        exp_f.push_back(1'b0);
      end else if (trunc < 0 || k < trunc) begin
        exp_w.push_back(w);
        if (k == nw - 1) exp_f.push_back(expf);
      end
      put(w);
    end
    repeat (gap) tick();
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_w.size() != 0 || exp_f.size() != 0) && t < 50) begin
      tick();
      t++;
    end
    if (exp_w.size() != 0 || exp_f.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d writes and %0d flags outstanding, expected 0", exp_w.size(), exp_f.size());
      exp_w = {};
      exp_f = {};
    end
    tick();
    tick();
  endtask
  initial begin
    logic [138:0] w;
    int a, f, n, cor, tr, nw;
    tbl[0] = '{64, -1, -1, 1'b1, 4};
    tbl[1] = '{64, 20, -1, 1'b0, 4};
    tbl[2] = '{67, -1, -1, 1'b1, 5};
    tbl[3] = '{63, -1, -1, 1'b0, 4};
    tbl[4] = '{17, -1, -1, 1'b0, 2};
    tbl[5] = '{80, -1, 3, 1'b0, 4};
    tbl[6] = '{128, 127, -1, 1'b0, 8};
    tbl[7] = '{96, -1, -1, 1'b1, 6};
    repeat (3) tick();
    chk("rst_wrreq", crc_check_wrreq, 0);
    chk("rst_data", crc_check_data, 0);
    chk("rst_flag", crc_result_wrreq, 0);
    chk("rst_result", crc_result, 0);
    chk("rst_ready", rx_ready, 0);
    reset = 1'b1;
    repeat (2) tick();
    foreach (tbl[i]) begin
      a = n_wr;
      f = n_flag;
      send_pkt(tbl[i].n, tbl[i].corrupt, tbl[i].trunc, 0, tbl[i].flag);
      drain();
      chk($sformatf("tbl%0d_writes", i), 139'(n_wr - a), 139'(tbl[i].nwr));
      chk($sformatf("tbl%0d_flags", i), 139'(n_flag - f), 139'(1));
    end
    a = n_wr;
    f = n_flag;
    w = rnd139();
    w[138:136] = 3'b100;
    put(w);
    drain();
    chk("stray_writes", 139'(n_wr - a), 0);
    chk("stray_flags", 139'(n_flag - f), 0);
    crc_usedw = 8'd160;
    tick();
    chk("rdy_160", rx_ready, 0);
    crc_usedw = 8'd159;
    chk("rdy_159_lat", rx_ready, 0);
    tick();
    chk("rdy_159", rx_ready, 1);
    crc_usedw = 8'd160;
    tick();
    chk("rdy_160_again", rx_ready, 0);
    crc_usedw = 8'd0;
    tick();
    send_pkt(64, -1, -1, 0, 1'b1);
    send_pkt(64, 20, -1, 0, 1'b0);
    send_pkt(70, -1, -1, 0, 1'b1);
    drain();
    rnd_usedw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(17, 200);
      nw = (n + 15) / 16;
      cor = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, n - 1)) : -1;
      tr = ($urandom_range(0, 7) == 0 && nw > 2) ? int'($urandom_range(1, nw - 2)) : -1;
      if ($urandom_range(0, 7) == 0) begin
        w = rnd139();
        w[138:136] = 3'b100;
        put(w);
      end
      send_pkt(n, cor, tr, $urandom_range(0, 2), cor < 0 && tr < 0 && n >= 64);
    end
    rnd_usedw = 1'b0;
    crc_usedw = 8'd0;
    drain();
    w = rnd139();
    w[138:136] = 3'b101;
    exp_w.push_back(w);
    put(w);
    w = rnd139();
    w[138:136] = 3'b100;
    exp_w.push_back(w);
    put(w);
    tick();
    tick();
    reset = 1'b0;
    #2;
    chk("rstmid_wrreq", crc_check_wrreq, 0);
    chk("rstmid_data", crc_check_data, 0);
    chk("rstmid_flag", crc_result_wrreq, 0);
    chk("rstmid_result", crc_result, 0);
    chk("rstmid_ready", rx_ready, 0);
    exp_w = {};
    exp_f = {};
    n_good = 0;
    n_bad = 0;
    tick();
    reset = 1'b1;
    tick();
`ifdef CRC_CHECK_STATS_EN
    chk("stats_rst_good", pkt_good_cnt, 0);
    chk("stats_rst_bad", pkt_bad_cnt, 0);
`endif
    send_pkt(64, -1, -1, 1, 1'b1);
    send_pkt(64, 20, -1, 0, 1'b0);
    send_pkt(100, -1, -1, 0, 1'b1);
    send_pkt(40, -1, -1, 2, 1'b0);
    send_pkt(67, -1, -1, 0, 1'b1);
    drain();
    chk("model_good", 139'(n_good), 139'(3));
    chk("model_bad", 139'(n_bad), 139'(2));
`ifdef CRC_CHECK_STATS_EN
    chk("pkt_good_cnt", pkt_good_cnt, 3);
    chk("pkt_bad_cnt", pkt_bad_cnt, 2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crc_check.md
CRC_CHECK -- requirements
Module: crc_check

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic rises on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port rx_wrreq, input, 1 bit: input word strobe from the receive MAC side.
REQ-004 SHALL have port rx_data, input, 139 bits, with these fields:
- [138:136] type: 101 = header, 110 = tail, 100 = middle.
- [135:132] on tail: valid bytes minus 1.
- [131:128] unused.
- [127:0] data; byte 0 is [127:120].
REQ-005 SHALL have port rx_ready, output, 1 bit: room for one maximum packet downstream.
REQ-006 SHALL have port crc_check_wrreq, output, 1 bit: write strobe into the level-2 data FIFO.
REQ-007 SHALL have port crc_check_data, output, 139 bits: word written into the level-2 data FIFO.
REQ-008 SHALL have port crc_usedw, input, 8 bits: level-2 data FIFO fill level.
REQ-009 SHALL have port crc_result_wrreq, output, 1 bit: one strobe per packet into the flag FIFO.
REQ-010 SHALL have port crc_result, output, 1 bit: 1 = packet good, 0 = discard.

Function
REQ-011 SHALL register the data path with 1-cycle latency: an accepted rx word appears on crc_check_data/crc_check_wrreq on the next cycle, unmodified except per REQ-016.
REQ-012 SHALL drive rx_ready as a register equal to (crc_usedw < 8'd160); words arriving while rx_ready is 0 SHALL still be accepted.
REQ-013 SHALL implement an FSM with states IDLE, PKT and DROP.
- IDLE, header: write the word, go to PKT.
- IDLE, any other type: drop the word, stay in IDLE.
- PKT, middle: write the word.
- PKT, tail: write the word, go to IDLE.
- DROP: drop all words until a header, which is handled as in IDLE.
REQ-014 SHALL compute Ethernet CRC-32 over the packet:
- Polynomial: reflected 0xEDB88320.
- Initial value 0xFFFFFFFF, loaded on each header.
- Input: bytes 0..15 of header and middle words, and bytes 0..[135:132] of the tail, FCS included.
REQ-015 SHALL set crc_result = 1 only if the CRC register after the tail equals residue 0xDEBB20E3 and the packet is at least 64 bytes; otherwise crc_result = 0.
REQ-016 SHALL, on a header received in PKT, write that word as a forced tail (type 110, [135:132] = 4'b1111), report crc_result = 0, and go to DROP.
REQ-017 SHALL assert crc_result_wrreq for exactly one cycle, on the cycle after the tail's crc_check_wrreq; every tail written SHALL have exactly one flag.
REQ-018 SHALL handle back-to-back packets: a header on the cycle after a tail SHALL reinitialise the CRC with no bubble, and the previous flag SHALL be unaffected.
REQ-019 SHALL count the packet length in bytes with a 12-bit counter that saturates at 4095.

Reset
REQ-020 SHALL, while reset is low, force the following values asynchronously:
- FSM to IDLE.
- crc_check_wrreq = 0, crc_result_wrreq = 0, crc_result = 0, rx_ready = 0.
- crc_check_data = 0, CRC register = 0xFFFFFFFF, length counter = 0.
REQ-021 SHALL, on reset asserted mid-packet, lose the partial packet; the downstream FIFOs are cleared by the same reset.

Configuration
REQ-022 SHALL, with macro CRC_CHECK_STATS_EN defined, add outputs pkt_good_cnt[31:0] and pkt_bad_cnt[31:0]:
- Each increments on a crc_result_wrreq with crc_result 1 or 0 respectively.
- Both wrap modulo 2^32 and reset to 0.
REQ-023 SHALL, without CRC_CHECK_STATS_EN, omit these counters and ports entirely.

Structure
REQ-024 SHALL place the following in shared package cdp_pkg:
- Type codes HDR = 3'b101, TAIL = 3'b110, MID = 3'b100.
- CRC_POLY, CRC_INIT and CRC_RESIDUE.
- MIN_PKT_BYTES = 64 and the rx_ready threshold 160.
REQ-025 SHALL implement the byte-masked 16-byte CRC update as sub-module crc32_d128, which is purely combinational: inputs crc_in, data, nbytes; output crc_out.

Verification
REQ-026 SHALL cover: a 64-byte good frame (header, 2 middles, tail [135:132] = 4'b1111) -> 4 writes, then crc_result_wrreq with crc_result = 1, 1 cycle after the tail write.
REQ-027 SHALL cover: the same frame with byte 20 flipped -> 4 writes, crc_result = 0.
REQ-028 SHALL cover: a 67-byte frame with tail [135:132] = 4'b0010 -> CRC over 3 tail bytes, crc_result = 1.
REQ-029 SHALL cover: a header at word 3 of a packet -> word 3 written as type 110/4'b1111, crc_result = 0; following middles and the tail are dropped; the next header is accepted.
REQ-030 SHALL cover: a middle word while in IDLE -> no write, no flag.
REQ-031 SHALL cover: crc_usedw driven 159 then 160 -> rx_ready 1 then 0, one cycle later; with CRC_CHECK_STATS_EN, after 3 good and 2 bad packets -> pkt_good_cnt = 3, pkt_bad_cnt = 2.
